// File: rtl/spi_slave.sv
// spi_slave: SPI slave with synchronised mclk/mosi/cs, a single-word
// transmit holding buffer and CPOL/CPHA-selectable edge roles.
module spi_slave #(
  parameter int WIDTH       = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mclk,
  input  logic             mosi,
  input  logic             cs,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun,
  output logic             busy,
  output logic             miso
);

  localparam int   CW          = $clog2(WIDTH);
  localparam logic CLK_IDLE    = (CPOL != 0);
  localparam logic SAMPLE_RISE = (CPOL == CPHA);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACTIVE = 1'b1;

  logic [SYNC_STAGES-1:0] mclk_sq, cs_sq, mosi_sq;
  logic                   mclk_pq, cs_pq;

  logic                   mclk_s, cs_s, mosi_s;
  logic                   mclk_rise, mclk_fall;
  logic                   sample_e, shift_e;
  logic                   cs_fall, cs_rise;

  logic [0:0]             state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [WIDTH-1:0]       rxs_q, rxs_d;
  logic [WIDTH-1:0]       txs_q, txs_d;
  logic [WIDTH-1:0]       hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [WIDTH-1:0]       rx_data_q, rx_data_d;
  logic                   rx_valid_q, rx_valid_d;
  logic                   ur_q, ur_d;
  logic                   miso_q, miso_d;

  logic                   load;
  logic                   direct;
  logic [WIDTH-1:0]       rx_word;
  logic [WIDTH-1:0]       ld_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mclk_sq <= {SYNC_STAGES{CLK_IDLE}};
      cs_sq   <= '1;
      mosi_sq <= '0;
      mclk_pq <= CLK_IDLE;
      cs_pq   <= 1'b1;
    end else begin
      mclk_sq <= {mclk_sq[SYNC_STAGES-2:0], mclk};
      cs_sq   <= {cs_sq[SYNC_STAGES-2:0], cs};
      mosi_sq <= {mosi_sq[SYNC_STAGES-2:0], mosi};
      mclk_pq <= mclk_sq[SYNC_STAGES-1];
      cs_pq   <= cs_sq[SYNC_STAGES-1];
    end
  end

  assign mclk_s    = mclk_sq[SYNC_STAGES-1];
  assign cs_s      = cs_sq[SYNC_STAGES-1];
  assign mosi_s    = mosi_sq[SYNC_STAGES-1];
  assign mclk_rise = mclk_s & ~mclk_pq;
  assign mclk_fall = ~mclk_s & mclk_pq;
  assign sample_e  = SAMPLE_RISE ? mclk_rise : mclk_fall;
  assign shift_e   = SAMPLE_RISE ? mclk_fall : mclk_rise;
  assign cs_fall   = cs_pq & ~cs_s;
  assign cs_rise   = ~cs_pq & cs_s;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rxs_d       = rxs_q;
    txs_d       = txs_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    ur_d        = 1'b0;
    miso_d      = miso_q;
    load        = 1'b0;
    direct      = 1'b0;
    ld_word     = '0;
    rx_word     = {rxs_q[WIDTH-2:0], mosi_s};

    case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d = ACTIVE;
          cnt_d   = '0;
          if (CPHA == 0) load = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          cnt_d   = '0;
          miso_d  = 1'b0;
        end else begin
          if (sample_e) begin
            rxs_d = rx_word;
            if (cnt_q == CW'(WIDTH-1)) begin
              rx_data_d  = rx_word;
              rx_valid_d = 1'b1;
              cnt_d      = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          if (shift_e) begin
            if (cnt_q == '0) begin
              load = 1'b1;
            end else begin
              txs_d  = txs_q << 1;
              miso_d = txs_q[WIDTH-2];
            end
          end
        end
      end
    endcase

    // A word load prefers the buffer, then a same-cycle write, then zeros.
    if (load) begin
      if (hold_full_q) begin
        ld_word     = hold_q;
        hold_full_d = 1'b0;
      end else if (tx_load) begin
        ld_word = tx_data;
        direct  = 1'b1;
      end else begin
        ur_d = 1'b1;
      end
      txs_d  = ld_word;
      miso_d = ld_word[WIDTH-1];
    end

    if (tx_load && !hold_full_q && !direct) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rxs_q       <= '0;
      txs_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      ur_q        <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rxs_q       <= rxs_d;
      txs_q       <= txs_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      ur_q        <= ur_d;
      miso_q      <= miso_d;
    end
  end

  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_underrun = ur_q;
  assign busy        = ~cs_s;
  assign miso        = miso_q & ~cs_s;

endmodule
